// File: rtl/os_phase_gate_pkg.sv
// Shared types and helpers for the oversampled PFB pacing stage.
//   state_e  : gate FSM states
//   PHA_W    : phase width for the default FFT_LEN build
//   CYC_W    : slot counter width for the default FFT_LEN build
//   pha_dec  : phase decrement modulo the branch count
package os_pkg;

  localparam int unsigned FFT_LEN_DFLT = 32;
  localparam int unsigned PHA_W        = $clog2(FFT_LEN_DFLT);
  localparam int unsigned CYC_W        = $clog2(FFT_LEN_DFLT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  // Commutator steps backwards through the branches, wrapping 0 -> m-1.
  function automatic int unsigned pha_dec(input int unsigned p, input int unsigned m);
    return (p == 0) ? (m - 1) : (p - 1);
  endfunction

endpackage

// File: rtl/os_phase_gate_if.sv
// AXI-Stream data channel (tdata/tvalid/tready).
//   master : drives tdata/tvalid, receives tready
//   slave  : receives tdata/tvalid, drives tready
interface axis_if #(
  parameter int unsigned W = 32
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/os_phase_gate_phase_ctr.sv
// Commutator phase register.
//   clk, rst : clock, synchronous active-high reset (loads SRT_PHA)
//   load     : reload SRT_PHA (wins over adv)
//   adv      : step phase down by one, modulo FFT_LEN
//   phase    : current phase
module os_phase_ctr
  import os_pkg::*;
#(
  parameter int unsigned FFT_LEN = FFT_LEN_DFLT,
  parameter int unsigned SRT_PHA = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       adv,
  output logic [$clog2(FFT_LEN)-1:0] phase
);

  localparam int unsigned PW = (FFT_LEN == FFT_LEN_DFLT) ? PHA_W : $clog2(FFT_LEN);

  logic [PW-1:0] phase_q, phase_d;

  // Next phase: reload on stop, decrement on each consumed beat.
  always_comb begin
    phase_d = phase_q;
    if (load)     phase_d = PW'(SRT_PHA);
    else if (adv) phase_d = PW'(pha_dec(32'(phase_q), FFT_LEN));
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= PW'(SRT_PHA);
    else     phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/os_phase_gate.sv
// AXIS pacing stage: passes DEC_FAC samples per FFT_LEN-cycle frame, pauses
// for the rest, and tags every beat with its commutator phase.
//   clk, rst     : clock, synchronous active-high reset
//   en           : run request; stopping takes effect at a frame boundary
//   s_axis       : input stream (NCHAN*2*TDATA_WIDTH bits)
//   m_axis       : output stream, combinational pass-through in consume slots
//   m_axis_tlast : last consumed beat of the frame
//   phase        : phase of the current m_axis beat
//   frame_cnt    : completed frames, wraps
//   running      : FSM in RUN
//   underflow    : sticky, input starved while downstream was ready
module os_phase_gate
  import os_pkg::*;
#(
  parameter int unsigned TDATA_WIDTH     = 16,
  parameter int unsigned NCHAN           = 1,
  parameter int unsigned FFT_LEN         = FFT_LEN_DFLT,
  parameter int unsigned DEC_FAC         = 24,
  parameter int unsigned SRT_PHA         = 23,
  parameter int unsigned FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  axis_if.slave                      s_axis,
  axis_if.master                     m_axis,
  output logic                       m_axis_tlast,
  output logic [$clog2(FFT_LEN)-1:0] phase,
  output logic [FRAME_CNT_WIDTH-1:0] frame_cnt,
  output logic                       running,
  output logic                       underflow
);

  localparam int unsigned CW = (FFT_LEN == FFT_LEN_DFLT) ? CYC_W : $clog2(FFT_LEN);
  localparam int unsigned FW = FRAME_CNT_WIDTH;

  state_e        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [FW-1:0] frame_q, frame_d;
  logic          uf_q, uf_d;
  logic          pha_load, pha_adv;
  logic          consume_c, xfer_c, frame_end_c;

  // Slot decode; compared in 32 bits so DEC_FAC == FFT_LEN cannot alias to 0.
  assign consume_c   = (state_q == RUN) && (32'(cyc_q) < DEC_FAC);
  assign xfer_c      = consume_c && s_axis.tvalid && m_axis.tready;
  assign frame_end_c = (state_q == RUN) && (32'(cyc_q) == FFT_LEN - 1) &&
                       (!consume_c || xfer_c);

  // Next state, slot/frame counters and stream steering.
  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    frame_d       = frame_q;
    uf_d          = uf_q;
    pha_load      = 1'b0;
    pha_adv       = 1'b0;
    m_axis.tdata  = s_axis.tdata;
    m_axis.tvalid = 1'b0;
    s_axis.tready = 1'b0;
    m_axis_tlast  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (en) state_d = ARMED;
      end
      ARMED: begin
        if (!en)               state_d = IDLE;
        else if (s_axis.tvalid) state_d = RUN;
      end
      RUN: begin
        if (consume_c) begin
          m_axis.tvalid = s_axis.tvalid;
          s_axis.tready = m_axis.tready;
          m_axis_tlast  = (32'(cyc_q) == DEC_FAC - 1);
          if (m_axis.tready && !s_axis.tvalid) uf_d = 1'b1;
          if (xfer_c) begin
            cyc_d   = cyc_q + CW'(1);
            pha_adv = 1'b1;
            if (m_axis_tlast) frame_d = frame_q + FW'(1);
          end
        end else begin
          // Pause slots tick regardless of handshake.
          cyc_d = cyc_q + CW'(1);
        end
        if (frame_end_c) begin
          cyc_d = '0;
          if (!en) begin
            state_d  = IDLE;
            pha_load = 1'b1;
          end
        end
      end
      default: state_d = state_e'('x);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      frame_q <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      frame_q <= frame_d;
      uf_q    <= uf_d;
    end
  end

  os_phase_ctr #(
    .FFT_LEN (FFT_LEN),
    .SRT_PHA (SRT_PHA)
  ) u_phase_ctr (
    .clk   (clk),
    .rst   (rst),
    .load  (pha_load),
    .adv   (pha_adv),
    .phase (phase)
  );

  assign frame_cnt = frame_q;
  assign running   = (state_q == RUN);
  assign underflow = uf_q;

endmodule

// File: tb/tb_os_phase_gate.sv
// Scoreboard bench for os_phase_gate: a default instance (D=24, M=32) and a
// four-lane instance with D=M=32.
module tb_os_phase_gate;

  localparam int unsigned WA = 32;
  localparam int unsigned WB = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_en, a_tlast, a_run, a_uf;
  logic        b_rst, b_en, b_tlast, b_run, b_uf;
  logic [4:0]  a_phase, b_phase;
  logic [15:0] a_fcnt, b_fcnt;

  axis_if #(.W(WA)) a_s ();
  axis_if #(.W(WA)) a_m ();
  axis_if #(.W(WB)) b_s ();
  axis_if #(.W(WB)) b_m ();

  os_phase_gate u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .s_axis(a_s), .m_axis(a_m),
    .m_axis_tlast(a_tlast), .phase(a_phase), .frame_cnt(a_fcnt),
    .running(a_run), .underflow(a_uf)
  );

  os_phase_gate #(.NCHAN(4), .DEC_FAC(32)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .s_axis(b_s), .m_axis(b_m),
    .m_axis_tlast(b_tlast), .phase(b_phase), .frame_cnt(b_fcnt),
    .running(b_run), .underflow(b_uf)
  );

  typedef struct {
    logic [127:0] data;
    logic [4:0]   pha;
    logic         last;
  } beat_t;

  beat_t a_q[$];
  beat_t b_q[$];
  int checks = 0;
  int errors = 0;
  int a_seen = 0;
  int b_seen = 0;
  int a_src = 0, a_pseq = 0, b_src = 0, b_pseq = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] a_dat(input int s);
    return {16'(s), 16'(s) ^ 16'hBEEF};
  endfunction

  function automatic logic [127:0] b_dat(input int s);
    return {32'(s) + 32'h3000_0000, 32'(s) + 32'h2000_0000,
            32'(s) + 32'h1000_0000, 32'(s)};
  endfunction

  // Frame f, beat j: phase = (SRT_PHA - f*D - j) mod 32.
  function automatic logic [4:0] exp_pha(input int f, input int j, input int d);
    return 5'((23 + 2048 - f * d - j) % 32);
  endfunction

  task automatic push_a(input int f0, input int nfr);
    for (int f = f0; f < f0 + nfr; f++)
      for (int j = 0; j < 24; j++) begin
        beat_t e;
        e.data = 128'(a_dat(a_pseq));
        e.pha  = exp_pha(f, j, 24);
        e.last = (j == 23);
        a_q.push_back(e);
        a_pseq++;
      end
  endtask

  task automatic push_b(input int n);
    for (int k = 0; k < n; k++) begin
      beat_t e;
      e.data = b_dat(b_pseq);
      e.pha  = exp_pha(k / 32, k % 32, 32);
      e.last = ((k % 32) == 31);
      b_q.push_back(e);
      b_pseq++;
    end
  endtask

  // Called at a negedge: note a source transfer, advance source data after the edge.
  task automatic a_cyc();
    logic x;
    x = a_s.tvalid && a_s.tready;
    @(posedge clk);
    #1;
    if (x) a_src++;
    a_s.tdata = a_dat(a_src);
  endtask

  task automatic b_cyc();
    logic x;
    x = b_s.tvalid && b_s.tready;
    @(posedge clk);
    #1;
    if (x) b_src++;
    b_s.tdata = b_dat(b_src);
  endtask

  // Output monitors: every downstream transfer pops one expected beat.
  always @(negedge clk) begin
    if (!a_rst && a_m.tvalid && a_m.tready) begin
      if (a_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_extra_beat: got data %0h, expected no beat", a_m.tdata);
      end else begin
        beat_t e;
        e = a_q.pop_front();
        chk("a_data", 128'(a_m.tdata), e.data);
        chk("a_phase", 128'(a_phase), 128'(e.pha));
        chk("a_tlast", 128'(a_tlast), 128'(e.last));
      end
      a_seen++;
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_m.tvalid && b_m.tready) begin
      if (b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_extra_beat: got data %0h, expected no beat", b_m.tdata);
      end else begin
        beat_t e;
        e = b_q.pop_front();
        chk("b_data", b_m.tdata, e.data);
        chk("b_phase", 128'(b_phase), 128'(e.pha));
        chk("b_tlast", 128'(b_tlast), 128'(e.last));
      end
      b_seen++;
    end
  end

  initial begin
    int base;
    int n;
    a_rst = 1'b1; a_en = 1'b0; a_s.tvalid = 1'b0; a_s.tdata = '0; a_m.tready = 1'b0;
    b_rst = 1'b1; b_en = 1'b0; b_s.tvalid = 1'b0; b_s.tdata = '0; b_m.tready = 1'b0;

    // Reset values
    repeat (4) @(posedge clk);
    #1 a_rst = 1'b0;
    @(negedge clk);
    chk("a_rst_tvalid", 128'(a_m.tvalid), 128'(0));
    chk("a_rst_tready", 128'(a_s.tready), 128'(0));
    chk("a_rst_tlast", 128'(a_tlast), 128'(0));
    chk("a_rst_phase", 128'(a_phase), 128'(23));
    chk("a_rst_fcnt", 128'(a_fcnt), 128'(0));
    chk("a_rst_running", 128'(a_run), 128'(0));
    chk("a_rst_underflow", 128'(a_uf), 128'(0));
    a_cyc();
    a_en = 1'b1;
    a_m.tready = 1'b1;

    // Enabled but starved: stays ARMED, no underflow
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("a_armed_running", 128'(a_run), 128'(0));
      chk("a_armed_tready", 128'(a_s.tready), 128'(0));
      chk("a_armed_uf", 128'(a_uf), 128'(0));
      a_cyc();
    end
    a_s.tvalid = 1'b1;
    push_a(0, 4);
    @(negedge clk);
    a_cyc();

    // Four continuous frames; en drops during cyc 5 of frame 3
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < 32; c++) begin
        @(negedge clk);
        if (c == 0) chk("a_frame_cnt", 128'(a_fcnt), 128'(f));
        chk("a_running", 128'(a_run), 128'(1));
        if (c >= 24) begin
          chk("a_pause_tvalid", 128'(a_m.tvalid), 128'(0));
          chk("a_pause_tready", 128'(a_s.tready), 128'(0));
        end else begin
          chk("a_consume_tvalid", 128'(a_m.tvalid), 128'(1));
        end
        a_cyc();
        if (f == 3 && c == 4) a_en = 1'b0;
      end
    @(negedge clk);
    chk("a_stop_running", 128'(a_run), 128'(0));
    chk("a_stop_phase", 128'(a_phase), 128'(23));
    chk("a_stop_fcnt", 128'(a_fcnt), 128'(4));
    chk("a_stop_tvalid", 128'(a_m.tvalid), 128'(0));
    chk("a_stop_tready", 128'(a_s.tready), 128'(0));
    chk("a_stop_sb_empty", 128'(a_q.size()), 128'(0));
    a_cyc();

    // Restart at phase 23 with random downstream backpressure, 5 frames
    a_en = 1'b1;
    push_a(0, 5);
    base = a_seen;
    n = 0;
    while (a_seen < base + 120 && n < 4000) begin
      @(negedge clk);
      a_cyc();
      a_m.tready = 1'($urandom_range(0, 1));
      n++;
    end
    chk("a_rand_beats", 128'(a_seen - base), 128'(120));
    chk("a_rand_fcnt", 128'(a_fcnt), 128'(9));
    chk("a_rand_uf", 128'(a_uf), 128'(0));
    chk("a_rand_sb_empty", 128'(a_q.size()), 128'(0));

    // Starve the input for 3 cycles mid-consume with downstream ready
    a_m.tready = 1'b1;
    push_a(5, 2);
    base = a_seen;
    n = 0;
    while (a_seen < base + 5 && n < 200) begin
      @(negedge clk);
      a_cyc();
      n++;
    end
    a_s.tvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      a_cyc();
    end
    a_s.tvalid = 1'b1;
    @(negedge clk);
    chk("a_uf_set", 128'(a_uf), 128'(1));
    a_cyc();
    n = 0;
    while (a_seen < base + 48 && n < 400) begin
      @(negedge clk);
      a_cyc();
      n++;
    end
    chk("a_uf_beats", 128'(a_seen - base), 128'(48));
    chk("a_uf_sticky", 128'(a_uf), 128'(1));
    chk("a_uf_sb_empty", 128'(a_q.size()), 128'(0));
    a_en = 1'b0;

    // Four lanes, D = M: no pause slots, then reset mid-frame
    b_en = 1'b1;
    b_s.tvalid = 1'b1;
    b_m.tready = 1'b1;
    b_s.tdata = b_dat(0);
    @(posedge clk);
    #1 b_rst = 1'b0;
    push_b(42);
    repeat (2) begin
      @(negedge clk);
      b_cyc();
    end
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      chk("b_no_pause", 128'(b_m.tvalid), 128'(1));
      if (k == 32) chk("b_frame_cnt", 128'(b_fcnt), 128'(1));
      b_cyc();
    end
    b_rst = 1'b1;
    @(posedge clk);
    #1;
    chk("b_rst_tvalid", 128'(b_m.tvalid), 128'(0));
    chk("b_rst_tready", 128'(b_s.tready), 128'(0));
    chk("b_rst_tlast", 128'(b_tlast), 128'(0));
    chk("b_rst_phase", 128'(b_phase), 128'(23));
    chk("b_rst_fcnt", 128'(b_fcnt), 128'(0));
    chk("b_rst_running", 128'(b_run), 128'(0));
    chk("b_rst_underflow", 128'(b_uf), 128'(0));
    chk("b_beats", 128'(b_seen), 128'(42));
    chk("b_sb_empty", 128'(b_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
